// File: rtl/axis_pkg.sv
// axis_pkg: shared types for the byte-lane AXI-Stream blocks.
//   AXIS_WORD_W / AXIS_BUS_W : default lane width and bus width
//   beat_t                   : one stream beat (data, keep, last) at the default widths
//   wr_state_t               : write-side FSM states of the packet FIFO
//   ptr_w()                  : width of a FIFO pointer that wraps modulo 2*depth
package axis_pkg;

    localparam int AXIS_WORD_W         = 8;
    localparam int AXIS_BUS_W          = 32;
    localparam int AXIS_WORDS_PER_BEAT = AXIS_BUS_W / AXIS_WORD_W;

    typedef struct packed {
        logic [AXIS_WORDS_PER_BEAT-1:0][AXIS_WORD_W-1:0] data;
        logic [AXIS_WORDS_PER_BEAT-1:0]                  keep;
        logic                                            last;
    } beat_t;

    // ACCEPT stores beats; DROP swallows the rest of a packet that overflowed.
    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_t;

    // One extra bit beyond the address so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM of stream beats with a registered read port.
//   clk, rst          : clock; async active-high reset clears only the read register
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr     : read request; rd_data updates on the edge and holds otherwise
//   rd_data           : registered read data, 0 after reset
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter type T     = beat_t,
    parameter int  DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  T              wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output T              rd_data
);

    T mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the master-side output register, so it
    // must hold while no read is requested and read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward AXI-Stream packet FIFO.
// A packet becomes visible on the master side only once its last beat is stored.
//   clk, rst                  : clock, async active-high reset
//   s_valid/s_ready           : slave handshake; s_data, s_keep, s_last beat fields
//   m_valid/m_ready           : master handshake; m_data, m_keep, m_last beat fields
//   pkt_count                 : complete packets stored (including the one being presented)
//   drop                      : one-cycle pulse when an overflowing packet is discarded
// Optional feature macro: AXIS_PKT_FIFO_DROP_EN (drop packets that overflow
// mid-packet instead of back-pressuring; without it drop is tied 0).
//
// Handshake: a beat transfers on a rising edge where valid && ready. Valid never
// depends on ready; once m_valid is high the master beat is held until taken.
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int  WORD_W         = AXIS_WORD_W,
    parameter int  BUS_W          = AXIS_BUS_W,
    parameter int  DEPTH          = 64,
    localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
    localparam int CNT_W          = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
    input  logic [WORDS_PER_BEAT-1:0]            s_keep,
    input  logic                                 s_last,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data,
    output logic [WORDS_PER_BEAT-1:0]            m_keep,
    output logic                                 m_last,
    output logic [CNT_W-1:0]                     pkt_count,
    output logic                                 drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    typedef struct packed {
        logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data;
        logic [WORDS_PER_BEAT-1:0]             keep;
        logic                                  last;
    } fifo_beat_t;

    // wr_ptr: next slot to write (speculative, may hold a partial packet)
    // cm_ptr: end of the committed region (one past the last stored s_last)
    // rd_ptr: oldest unconsumed beat; the beat in the output register still
    //         occupies its slot until the master side takes it
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fetch_ptr;

    logic          ready_en;
    logic          full;
    logic          s_fire;
    logic          m_fire;
    logic          wr_en;
    logic          commit;
    logic          rollback;
    logic          load;
    fifo_beat_t    wr_beat;
    fifo_beat_t    rd_beat;

    // Holds s_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign full   = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;
    assign commit = wr_en && s_last;

`ifdef AXIS_PKT_FIFO_DROP_EN
    wr_state_t wr_state;
    wr_state_t wr_state_next;
    logic      mid_pkt;
    logic      discard;

    assign mid_pkt  = wr_ptr != cm_ptr;
    // A packet that runs into full after its first beat keeps s_ready high
    // and is swallowed; a packet that has not started yet simply waits.
    assign s_ready  = ready_en && (!full || mid_pkt);
    assign discard  = s_fire && ((wr_state == WR_DROP) || full);
    assign wr_en    = s_fire && !discard;
    assign rollback = discard && s_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_ACCEPT;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            WR_ACCEPT: if (discard && !s_last) wr_state_next = WR_DROP;
            WR_DROP:   if (rollback)           wr_state_next = WR_ACCEPT;
            default:                           wr_state_next = WR_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else begin
            drop <= rollback;
        end
    end
`else
    assign s_ready  = ready_en && !full;
    assign wr_en    = s_fire;
    assign rollback = 1'b0;
    assign drop     = 1'b0;
`endif

    // Write side: speculative pointer and commit pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
        end else begin
            if (rollback) begin
                wr_ptr <= cm_ptr;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (commit) begin
                cm_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    // Read lookahead: the next beat to fetch sits just past whatever the output
    // register holds. Fetch whenever the register is empty or being emptied and
    // committed data remains, giving one beat per cycle under m_ready.
    assign fetch_ptr = rd_ptr + PW'(m_valid);
    assign load      = (!m_valid || m_ready) && (fetch_ptr != cm_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (m_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            m_valid <= load || (m_valid && !m_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            case ({commit, m_fire && m_last})
                2'b10:   pkt_count <= pkt_count + CNT_W'(1);
                2'b01:   pkt_count <= pkt_count - CNT_W'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    assign wr_beat.data = s_data;
    assign wr_beat.keep = s_keep;
    assign wr_beat.last = s_last;

    axis_fifo_ram #(
        .T     (fifo_beat_t),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_beat),
        .rd_en   (load),
        .rd_addr (fetch_ptr[AW-1:0]),
        .rd_data (rd_beat)
    );

    assign m_data = rd_beat.data;
    assign m_keep = rd_beat.keep;
    assign m_last = rd_beat.last;

endmodule
